traffic_light_fsm: RTL and testbench
====================================

# traffic_light_fsm

Intersection sequencer for the Traffic Light project. It sits directly downstream of the one-second tick generator and consumes its single-cycle rollover pulse. It steps a two-direction (NS/EW) signal-head state machine with fixed per-phase durations counted in seconds, and serves a latched pedestrian request with an all-red WALK phase. Outputs drive the board's LEDs and a seconds-remaining value for display.

## Interface
- GREEN_SEC, 10: green phase length in ticks (1..255)
- YELLOW_SEC, 3: yellow phase length in ticks (1..255)
- ALLRED_SEC, 1: all-red clearance length in ticks (1..255)
- WALK_SEC, 8: pedestrian WALK phase length in ticks (1..255)
- CLK  in  1  system clock; single clock domain
- RS  in  1  reset; synchronous, active-high
- CE  in  1  clock enable; TICK is accepted only when CE=1
- TICK  in  1  one-cycle pulse per second from the tick generator
- PED_BTN  in  1  raw pedestrian pushbutton, asynchronous
- NS_LIGHT  out  3  {R,Y,G} for north-south head, one-hot
- EW_LIGHT  out  3  {R,Y,G} for east-west head, one-hot
- WALK  out  1  pedestrian WALK lamp
- PED_PEND  out  1  pedestrian request latched, not yet served
- SEC_LEFT  out  8  remaining ticks in current phase minus one
- STATE  out  3  current state encoding (debug/display)

## Operation
- States: ALL_RED_A(0), NS_GREEN(1), NS_YELLOW(2), ALL_RED_B(3), EW_GREEN(4), EW_YELLOW(5), WALK_PH(6). Encoding 7 unused; if reached, go to ALL_RED_A next cycle.
- Normal cycle: ALL_RED_A→NS_GREEN→NS_YELLOW→ALL_RED_B→EW_GREEN→EW_YELLOW→ALL_RED_A.
- Lights: NS_GREEN NS=001 EW=100; NS_YELLOW NS=010 EW=100; EW_GREEN NS=100 EW=001; EW_YELLOW NS=100 EW=010; ALL_RED_*, WALK_PH both 100. WALK=1 only in WALK_PH. Never two non-red heads simultaneously.
- Phase counter: loaded with DUR-1 on phase entry; each accepted tick (TICK&CE) decrements; accepted tick at 0 ends the phase. Each phase lasts exactly DUR accepted ticks.
- Pedestrian: PED_BTN passes a 2-flop synchronizer, rising edge sets PED_PEND. When ALL_RED_A or ALL_RED_B expires with PED_PEND=1, go to WALK_PH instead, storing the skipped successor (NS_GREEN or EW_GREEN); WALK_PH expiry goes to the stored successor.
- PED_PEND clears on WALK_PH entry; rising edges during WALK_PH are ignored; edges in any other state latch (multiple presses = one request).
- CE=0: ticks ignored, state/counter frozen; button synchronizer and PED_PEND latch keep running.
- RS priority over everything, including a coincident tick or button edge.

## Timing
- All outputs registered.
- Reset values: STATE=ALL_RED_A, NS_LIGHT=100, EW_LIGHT=100, WALK=0, PED_PEND=0, SEC_LEFT=ALLRED_SEC-1, synchronizer flops 0, stored successor=NS_GREEN.
- Transition latency: outputs show new state and SEC_LEFT=DUR-1 on the cycle after the accepted terminal tick.
- SEC_LEFT updates the cycle after each accepted tick.
- PED_BTN to PED_PEND: 3 cycles (2 sync + edge register).
- Button edge in the same cycle the all-red expires: not yet visible in PED_PEND, so not served this cycle; served at the next all-red.
- DUR=1: phase ends on its first accepted tick.
- RS mid-phase: next cycle at reset values; pending request discarded.

## Structure
- Shared package/include traffic_pkg: state encodings, light codes (RED=100, YEL=010, GRN=001), SEC_LEFT width (8).
- Sub-module ped_req_sync: 2-flop synchronizer + rising-edge detect, outputs one-cycle PED_EDGE.
- Parameter range checks via elaboration-time assertion.

## Test plan
Params GREEN=5, YELLOW=2, ALLRED=1, WALK=3; TICK every 4 cycles, CE=1 unless stated.
- Reset then 22 ticks, no button -> states 0,1,2,3,4,5,0,1 with dwell 1,5,2,1,5,2,1 ticks; heads match table; SEC_LEFT counts 4..0 in greens.
- Press PED_BTN during NS_GREEN -> PED_PEND=1 after 3 cycles; after ALL_RED_B expiry WALK_PH for 3 ticks, WALK=1, both heads 100, then EW_GREEN; PED_PEND=0.
- Press PED_BTN 3 times during EW_GREEN -> single WALK_PH after ALL_RED_A, then NS_GREEN; press during WALK_PH -> no new request.
- CE=0 for 10 ticks during NS_YELLOW -> STATE and SEC_LEFT unchanged; PED_BTN press still sets PED_PEND.
- Assert RS coincident with terminal tick of EW_GREEN -> next cycle STATE=0, both heads 100, SEC_LEFT=0, PED_PEND=0.
- Throughout all runs, assertion: NS_LIGHT and EW_LIGHT never both non-100; each always one-hot.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared state encodings, lamp codes and widths for the
//               intersection sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam int         c_SEC_W = 8;

    // Lamp codes, ordered {R,Y,G}
    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    typedef enum logic [2:0] {
        S_ALL_RED_A = 3'd0,
        S_NS_GREEN  = 3'd1,
        S_NS_YELLOW = 3'd2,
        S_ALL_RED_B = 3'd3,
        S_EW_GREEN  = 3'd4,
        S_EW_YELLOW = 3'd5,
        S_WALK_PH   = 3'd6,
        S_UNUSED    = 3'd7
    } state_e;

    // Signal-head pattern for a state, returned as {NS, EW}. Anything that is
    // not a green/yellow phase shows red on both heads.
    function automatic logic [5:0] lights_of(input state_e s);
        case (s)
            S_NS_GREEN:  return {c_GRN, c_RED};
            S_NS_YELLOW: return {c_YEL, c_RED};
            S_EW_GREEN:  return {c_RED, c_GRN};
            S_EW_YELLOW: return {c_RED, c_YEL};
            default:     return {c_RED, c_RED};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_req_sync.sv
`default_nettype none
// ============================================================================
// Module      : ped_req_sync
// Description : Two-flop synchronizer for the raw pedestrian button followed
//               by a rising-edge detector producing a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_req_sync (
    input  logic clk_i,
    input  logic rs_i,
    input  logic btn_i,
    output logic ped_edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronize the asynchronous button and keep the previous sample for edge detection
    always_ff @(posedge clk_i) begin
        if (rs_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign ped_edge_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_fsm
// Description : Two-direction intersection sequencer with fixed per-phase
//               durations in seconds and a latched pedestrian all-red WALK
//               phase inserted after an all-red clearance.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_SEC  = 10,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1,
    parameter int WALK_SEC   = 8
) (
    input  logic               clk_i,
    input  logic               rs_i,
    input  logic               ce_i,
    input  logic               tick_i,
    input  logic               ped_btn_i,
    output logic [2:0]         ns_light_o,
    output logic [2:0]         ew_light_o,
    output logic               walk_o,
    output logic               ped_pend_o,
    output logic [c_SEC_W-1:0] sec_left_o,
    output logic [2:0]         state_o
);

    generate
        if (GREEN_SEC  < 1 || GREEN_SEC  > 255 ||
            YELLOW_SEC < 1 || YELLOW_SEC > 255 ||
            ALLRED_SEC < 1 || ALLRED_SEC > 255 ||
            WALK_SEC   < 1 || WALK_SEC   > 255) begin : g_bad_param
            $error("traffic_light_fsm: phase durations must lie in 1..255");
        end
    endgenerate

    localparam logic [c_SEC_W-1:0] c_GREEN_M1  = c_SEC_W'(GREEN_SEC  - 1);
    localparam logic [c_SEC_W-1:0] c_YELLOW_M1 = c_SEC_W'(YELLOW_SEC - 1);
    localparam logic [c_SEC_W-1:0] c_ALLRED_M1 = c_SEC_W'(ALLRED_SEC - 1);
    localparam logic [c_SEC_W-1:0] c_WALK_M1   = c_SEC_W'(WALK_SEC   - 1);

    // Counter preload for a phase: its duration minus one
    function automatic logic [c_SEC_W-1:0] dur_m1(input state_e s);
        case (s)
            S_NS_GREEN,  S_EW_GREEN:  return c_GREEN_M1;
            S_NS_YELLOW, S_EW_YELLOW: return c_YELLOW_M1;
            S_WALK_PH:                return c_WALK_M1;
            default:                  return c_ALLRED_M1;
        endcase
    endfunction

    state_e               state_q, state_d;
    state_e               succ_q,  succ_d;
    logic [c_SEC_W-1:0]   cnt_q,   cnt_d;
    logic                 pend_q,  pend_d;
    logic [2:0]           ns_q,    ns_d;
    logic [2:0]           ew_q,    ew_d;
    logic                 walk_q,  walk_d;
    logic                 w_ped_edge;
    logic                 w_acc;

    ped_req_sync u_ped_sync (
        .clk_i      (clk_i),
        .rs_i       (rs_i),
        .btn_i      (ped_btn_i),
        .ped_edge_o (w_ped_edge)
    );

    assign w_acc = tick_i & ce_i;

    // Next phase, counter, request latch and the lamp pattern of the next state
    always_comb begin
        state_d = state_q;
        succ_d  = succ_q;
        cnt_d   = cnt_q;
        // Presses during the WALK phase itself are not a new request
        pend_d  = pend_q | (w_ped_edge & (state_q != S_WALK_PH));

        if (state_q == S_UNUSED) begin
            state_d = S_ALL_RED_A;
            cnt_d   = c_ALLRED_M1;
        end else if (w_acc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                case (state_q)
                    S_ALL_RED_A: begin
                        if (pend_q) begin
                            state_d = S_WALK_PH;
                            succ_d  = S_NS_GREEN;
                        end else begin
                            state_d = S_NS_GREEN;
                        end
                    end
                    S_NS_GREEN:  state_d = S_NS_YELLOW;
                    S_NS_YELLOW: state_d = S_ALL_RED_B;
                    S_ALL_RED_B: begin
                        if (pend_q) begin
                            state_d = S_WALK_PH;
                            succ_d  = S_EW_GREEN;
                        end else begin
                            state_d = S_EW_GREEN;
                        end
                    end
                    S_EW_GREEN:  state_d = S_EW_YELLOW;
                    S_EW_YELLOW: state_d = S_ALL_RED_A;
                    S_WALK_PH:   state_d = succ_q;
                    default:     state_d = S_ALL_RED_A;
                endcase
                cnt_d = dur_m1(state_d);
                // Entering WALK serves the request, including any coincident press
                if (state_d == S_WALK_PH) begin
                    pend_d = 1'b0;
                end
            end
        end

        {ns_d, ew_d} = lights_of(state_d);
        walk_d       = (state_d == S_WALK_PH);
    end

    // State and registered outputs; reset overrides any coincident tick or press
    always_ff @(posedge clk_i) begin
        if (rs_i) begin
            state_q <= S_ALL_RED_A;
            succ_q  <= S_NS_GREEN;
            cnt_q   <= c_ALLRED_M1;
            pend_q  <= 1'b0;
            ns_q    <= c_RED;
            ew_q    <= c_RED;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            succ_q  <= succ_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            walk_q  <= walk_d;
        end
    end

    assign ns_light_o = ns_q;
    assign ew_light_o = ew_q;
    assign walk_o     = walk_q;
    assign ped_pend_o = pend_q;
    assign sec_left_o = cnt_q;
    assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_fsm
// Description : Self-checking bench for the intersection sequencer, using a
//               phase/seconds-remaining reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_fsm;

    localparam int G = 5;
    localparam int Y = 2;
    localparam int A = 1;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rs_i = 1'b0;
    logic       ce_i = 1'b0;
    logic       tick_i = 1'b0;
    logic       ped_btn_i = 1'b0;
    logic [2:0] ns_light_o;
    logic [2:0] ew_light_o;
    logic       walk_o;
    logic       ped_pend_o;
    logic [7:0] sec_left_o;
    logic [2:0] state_o;

    traffic_light_fsm #(
        .GREEN_SEC  (G),
        .YELLOW_SEC (Y),
        .ALLRED_SEC (A),
        .WALK_SEC   (W)
    ) dut (
        .clk_i      (clk),
        .rs_i       (rs_i),
        .ce_i       (ce_i),
        .tick_i     (tick_i),
        .ped_btn_i  (ped_btn_i),
        .ns_light_o (ns_light_o),
        .ew_light_o (ew_light_o),
        .walk_o     (walk_o),
        .ped_pend_o (ped_pend_o),
        .sec_left_o (sec_left_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Reference tables indexed by phase number
    int         dur_tab [7] = '{A, G, Y, A, G, Y, W};
    logic [2:0] ns_tab  [7] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab  [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reference model: phase, whole ticks left, pending request, resume phase
    int m_state = 0;
    int m_left  = A;
    int m_succ  = 1;
    bit m_pend  = 0;
    bit btn_hist [$] = '{1'b0, 1'b0, 1'b0};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model over one clock edge given the inputs present at it
    task automatic model_step(input bit t, input bit c, input bit r, input bit b);
        bit press;
        bit np;
        int nxt;
        if (r) begin
            m_state  = 0;
            m_left   = A;
            m_pend   = 0;
            m_succ   = 1;
            btn_hist = '{1'b0, 1'b0, 1'b0};
            return;
        end
        // A press becomes visible to the latch two samples after the button rises
        press = btn_hist[1] && !btn_hist[2];
        np    = m_pend || (press && m_state != 6);
        if (c && t) begin
            m_left--;
            if (m_left == 0) begin
                if ((m_state == 0 || m_state == 3) && m_pend) begin
                    m_succ = (m_state == 0) ? 1 : 4;
                    nxt    = 6;
                end else if (m_state == 6) begin
                    nxt = m_succ;
                end else begin
                    nxt = (m_state + 1) % 6;
                end
                m_state = nxt;
                m_left  = dur_tab[nxt];
                if (nxt == 6) np = 0;
            end
        end
        m_pend = np;
        btn_hist.push_front(b);
        void'(btn_hist.pop_back());
    endtask

    task automatic compare_all();
        chk("state",    32'(state_o),    32'(m_state));
        chk("sec_left", 32'(sec_left_o), 32'(m_left - 1));
        chk("ns_light", 32'(ns_light_o), 32'(ns_tab[m_state]));
        chk("ew_light", 32'(ew_light_o), 32'(ew_tab[m_state]));
        chk("walk",     32'(walk_o),     32'(m_state == 6));
        chk("ped_pend", 32'(ped_pend_o), 32'(m_pend));
        chk("heads_safe",
            {29'd0, $onehot(ns_light_o), $onehot(ew_light_o),
             !(ns_light_o != 3'b100 && ew_light_o != 3'b100)},
            32'd7);
    endtask

    task automatic do_cycle(input bit t, input bit c, input bit r, input bit b);
        tick_i    = t;
        ce_i      = c;
        rs_i      = r;
        ped_btn_i = b;
        model_step(t, c, r, b);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // One cycle with a tick on every fourth cycle
    task automatic pat_cycle(input bit c, input bit b, input bit r);
        bit t;
        t = (cyc % 4 == 3);
        cyc++;
        do_cycle(t, c, r, b);
    endtask

    task automatic run(input int n, input bit c, input bit b);
        for (int i = 0; i < n; i++) pat_cycle(c, b, 1'b0);
    endtask

    task automatic wait_for(input int s);
        bit found;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_state == s) begin
                found = 1;
                break;
            end
            pat_cycle(1'b1, 1'b0, 1'b0);
        end
        chk("wait_state", 32'(found), 32'd1);
    endtask

    initial begin
        bit done;
        bit b_rand;

        // Reset, then the plain cycle for 22 ticks
        pat_cycle(1'b1, 1'b0, 1'b1);
        pat_cycle(1'b1, 1'b0, 1'b1);
        chk("reset_sec_left", 32'(sec_left_o), 32'(A - 1));
        run(88, 1'b1, 1'b0);

        // Press during NS green, served after ALL_RED_B then EW green
        wait_for(1);
        run(6, 1'b1, 1'b1);
        run(100, 1'b1, 1'b0);

        // Three presses during EW green form a single request
        wait_for(4);
        for (int k = 0; k < 3; k++) begin
            run(3, 1'b1, 1'b1);
            run(3, 1'b1, 1'b0);
        end
        wait_for(6);
        run(4, 1'b1, 1'b1);
        run(60, 1'b1, 1'b0);
        chk("walk_press_ignored", 32'(ped_pend_o), 32'd0);

        // Clock enable low during NS yellow; button still latches
        wait_for(2);
        run(5, 1'b0, 1'b1);
        run(35, 1'b0, 1'b0);
        chk("ce_off_state", 32'(state_o), 32'd2);
        chk("ce_off_pend", 32'(ped_pend_o), 32'd1);
        run(60, 1'b1, 1'b0);

        // Reset coincident with the terminal tick of EW green, request pending
        wait_for(4);
        run(6, 1'b1, 1'b1);
        done = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_state == 4 && m_left == 1 && (cyc % 4 == 3)) begin
                pat_cycle(1'b1, 1'b0, 1'b1);
                done = 1;
                break;
            end
            pat_cycle(1'b1, 1'b0, 1'b0);
        end
        chk("rs_hit", 32'(done), 32'd1);
        chk("rs_state", 32'(state_o), 32'd0);
        chk("rs_sec_left", 32'(sec_left_o), 32'd0);
        chk("rs_pend", 32'(ped_pend_o), 32'd0);
        chk("rs_heads", 32'({ns_light_o, ew_light_o}), 32'h24);

        // Randomized traffic: irregular ticks, enable drops, button bursts, rare resets
        b_rand = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) b_rand = ~b_rand;
            do_cycle($urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) != 0,
                     $urandom_range(0, 599) == 0,
                     b_rand);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
